// File: rtl/wb_cmd_pkg.sv
// Shared types and constants for the Wishbone command initiator.
// Holds the FSM state encoding and the default bus widths.
package wb_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEFAULT_AW = 32;
  localparam int DEFAULT_DW = 32;

  // Read data reported when a cycle is abandoned without an acknowledge.
  localparam logic [DEFAULT_DW-1:0] RSP_DAT_ON_ERR = '0;

endpackage

// File: rtl/wb_cmd_initiator_if.sv
// Command, response and Wishbone master signals of the initiator in one bundle.
// 'master' is the initiator's view; 'slave' is the environment (command source, response sink, WB target).
interface wb_cmd_initiator_if
  import wb_cmd_pkg::*;
#(
  parameter int AW = DEFAULT_AW,
  parameter int DW = DEFAULT_DW
);
  localparam int SW = DW / 8;

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_adr;
  logic [DW-1:0] cmd_dat;
  logic [SW-1:0] cmd_sel;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_dat;
  logic          rsp_err;

  logic          wbm_cyc_o;
  logic          wbm_stb_o;
  logic          wbm_we_o;
  logic [AW-1:0] wbm_adr_o;
  logic [DW-1:0] wbm_dat_o;
  logic [SW-1:0] wbm_sel_o;
  logic [DW-1:0] wbm_dat_i;
  logic          wbm_ack_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
    output cmd_ready,
    output rsp_valid, rsp_dat, rsp_err,
    input  rsp_ready,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
    input  cmd_ready,
    input  rsp_valid, rsp_dat, rsp_err,
    output rsp_ready,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    output wbm_dat_i, wbm_ack_i
  );

endinterface

// File: rtl/wb_timeout_ctr.sv
// Ack-wait counter: cleared by load, counts enabled cycles, flags the TIMEOUT_CYCLES-th one.
// Only instantiated when WB_TIMEOUT_EN is defined.
module wb_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // The count reaches TIMEOUT_CYCLES at the end of this cycle, so flag it now to drop cyc on that edge.
  assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_cmd_initiator.sv
// Wishbone classic single-cycle initiator: one command in, one bus cycle, one response out.
// Optional ack timeout is built when the macro WB_TIMEOUT_EN is defined.
module wb_cmd_initiator
  import wb_cmd_pkg::*;
#(
  parameter int AW             = DEFAULT_AW,
  parameter int DW             = DEFAULT_DW,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  wb_cmd_initiator_if.master bus,
  output logic               busy
);
  localparam int SW = DW / 8;

  state_t        state;
  state_t        state_next;
  logic          cmd_ready_d;
  logic          accept;
  logic          timeout_hit;

  logic          cyc_q;
  logic          stb_q;
  logic          we_q;
  logic [AW-1:0] adr_q;
  logic [DW-1:0] dat_q;
  logic [SW-1:0] sel_q;
  logic          rsp_valid_q;
  logic [DW-1:0] rsp_dat_q;
  logic          rsp_err_q;

  assign accept = (state == IDLE) && bus.cmd_valid;

`ifdef WB_TIMEOUT_EN
  wb_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .load   (accept),
    .enable (state == BUS),
    .expired(timeout_hit)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0) | RSP_DAT_ON_ERR[0];
  assign timeout_hit        = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: default assignment first so no path through the case leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.cmd_valid) state_next = BUS;
      BUS:     if (bus.wbm_ack_i || timeout_hit) state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_d = (state == IDLE);
    busy        = (state != IDLE);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            we_q  <= bus.cmd_we;
            adr_q <= bus.cmd_adr;
            dat_q <= bus.cmd_dat;
            sel_q <= bus.cmd_sel;
            cyc_q <= 1'b1;
            stb_q <= 1'b1;
          end
        end
        BUS: begin
          // An ack on the expiry cycle still completes the cycle normally.
          if (bus.wbm_ack_i) begin
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_dat_q   <= we_q ? '0 : bus.wbm_dat_i;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
          end else if (timeout_hit) begin
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_dat_q   <= DW'(RSP_DAT_ON_ERR);
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) rsp_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_d;
  assign bus.wbm_cyc_o = cyc_q;
  assign bus.wbm_stb_o = stb_q;
  assign bus.wbm_we_o  = we_q;
  assign bus.wbm_adr_o = adr_q;
  assign bus.wbm_dat_o = dat_q;
  assign bus.wbm_sel_o = sel_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_dat   = rsp_dat_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Self-checking bench for wb_cmd_initiator: directed scenarios plus a random run,
// all compared every cycle against a transaction-level model of the initiator.
module tb_wb_cmd_initiator;

  localparam int TO_CYCLES = 8;
`ifdef WB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   started = 1'b0;

  wb_cmd_initiator_if #(.AW(32), .DW(32)) bus ();
  logic busy;

  wb_cmd_initiator #(
    .AW(32), .DW(32), .TIMEOUT_CYCLES(TO_CYCLES)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus     (bus),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  // Transaction-level model: phase 0 = waiting for a command, 1 = bus cycle open, 2 = response held.
  int          m_phase;
  int          m_bus_cycles;
  logic        m_cyc, m_we, m_rv, m_err;
  logic [31:0] m_adr, m_dat, m_rdat;
  logic [3:0]  m_sel;

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0; m_bus_cycles <= 0;
      m_cyc <= 1'b0; m_we <= 1'b0; m_adr <= '0; m_dat <= '0; m_sel <= '0;
      m_rv <= 1'b0; m_err <= 1'b0; m_rdat <= '0;
    end else if (m_phase == 0) begin
      if (bus.cmd_valid) begin
        m_phase <= 1; m_bus_cycles <= 0; m_cyc <= 1'b1;
        m_we <= bus.cmd_we; m_adr <= bus.cmd_adr; m_dat <= bus.cmd_dat; m_sel <= bus.cmd_sel;
      end
    end else if (m_phase == 1) begin
      m_bus_cycles <= m_bus_cycles + 1;
      if (bus.wbm_ack_i) begin
        m_phase <= 2; m_cyc <= 1'b0; m_rv <= 1'b1; m_err <= 1'b0;
        m_rdat <= m_we ? 32'h0 : bus.wbm_dat_i;
      end else if (TO_EN && (m_bus_cycles + 1 >= TO_CYCLES)) begin
        m_phase <= 2; m_cyc <= 1'b0; m_rv <= 1'b1; m_err <= 1'b1; m_rdat <= 32'h0;
      end
    end else if (bus.rsp_ready) begin
      m_phase <= 0; m_rv <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("cmd_ready", bus.cmd_ready, m_phase == 0);
      check("busy", busy, m_phase != 0);
      check("cyc", bus.wbm_cyc_o, m_cyc);
      check("stb", bus.wbm_stb_o, m_cyc);
      check("rsp_valid", bus.rsp_valid, m_rv);
      if (m_cyc) begin
        check("wbm_we", bus.wbm_we_o, m_we);
        check("wbm_adr", bus.wbm_adr_o, m_adr);
        check("wbm_dat", bus.wbm_dat_o, m_dat);
        check("wbm_sel", bus.wbm_sel_o, m_sel);
      end
      if (m_rv) begin
        check("rsp_dat", bus.rsp_dat, m_rdat);
        check("rsp_err", bus.rsp_err, m_err);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_adr   = adr;
    bus.cmd_dat   = dat;
    bus.cmd_sel   = sel;
  endtask

  initial begin
    int n_cyc;
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_adr = '0; bus.cmd_dat = '0; bus.cmd_sel = '0;
    bus.rsp_ready = 1'b0; bus.wbm_dat_i = '0; bus.wbm_ack_i = 1'b0;
    repeat (2) tick();
    started = 1'b1;

    // Reset state
    check("rst_cyc", bus.wbm_cyc_o, 0);
    check("rst_adr", bus.wbm_adr_o, 0);
    check("rst_rsp_dat", bus.rsp_dat, 0);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // Write, ack presented three cycles after stb rises
    set_cmd(1'b1, 32'h3000_0000, 32'hA5A5_1234, 4'hF);
    bus.rsp_ready = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("wr_cyc_held", bus.wbm_cyc_o, 1);
      check("wr_adr_held", bus.wbm_adr_o, 32'h3000_0000);
      check("wr_dat_held", bus.wbm_dat_o, 32'hA5A5_1234);
      tick();
    end
    bus.wbm_ack_i = 1'b1; bus.wbm_dat_i = 32'h1111_2222;
    tick();
    bus.wbm_ack_i = 1'b0;
    check("wr_rsp_valid", bus.rsp_valid, 1);
    check("wr_rsp_dat", bus.rsp_dat, 0);
    check("wr_rsp_err", bus.rsp_err, 0);
    check("wr_cyc_low", bus.wbm_cyc_o, 0);
    tick();
    check("wr_idle", bus.cmd_ready, 1);

    // Read, ack in the first bus cycle: response two cycles after the command
    set_cmd(1'b0, 32'h3000_0004, 32'h0, 4'hF);
    tick();
    bus.cmd_valid = 1'b0;
    check("rd_cyc", bus.wbm_cyc_o, 1);
    check("rd_we", bus.wbm_we_o, 0);
    bus.wbm_ack_i = 1'b1; bus.wbm_dat_i = 32'h0000_00C8;
    tick();
    bus.wbm_ack_i = 1'b0;
    check("rd_rsp_dat", bus.rsp_dat, 32'h0000_00C8);
    check("rd_cyc_low", bus.wbm_cyc_o, 0);
    tick();

    // Stray ack while idle
    bus.wbm_ack_i = 1'b1; bus.wbm_dat_i = 32'hDEAD_BEEF;
    tick();
    bus.wbm_ack_i = 1'b0;
    check("stray_idle_busy", busy, 0);
    check("stray_idle_rsp_dat", bus.rsp_dat, 32'h0000_00C8);

    // Backpressure with a second command held by the source, plus a stray ack in RESP
    bus.rsp_ready = 1'b0;
    set_cmd(1'b0, 32'h0000_0040, 32'h0, 4'h3);
    tick();
    set_cmd(1'b1, 32'h0000_0080, 32'hCAFE_F00D, 4'hC);
    bus.wbm_ack_i = 1'b1; bus.wbm_dat_i = 32'h0000_0055;
    tick();
    bus.wbm_ack_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_cmd_ready", bus.cmd_ready, 0);
      check("bp_rsp_valid", bus.rsp_valid, 1);
      check("bp_rsp_dat", bus.rsp_dat, 32'h0000_0055);
      bus.wbm_ack_i = (i == 2); bus.wbm_dat_i = 32'h0000_0099;
      tick();
    end
    bus.wbm_ack_i = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    check("bp_idle_ready", bus.cmd_ready, 1);
    check("bp_rsp_dropped", bus.rsp_valid, 0);
    tick();
    bus.cmd_valid = 1'b0;
    check("bp_second_cyc", bus.wbm_cyc_o, 1);
    check("bp_second_adr", bus.wbm_adr_o, 32'h0000_0080);
    bus.wbm_ack_i = 1'b1;
    tick();
    bus.wbm_ack_i = 1'b0;
    check("bp_second_rsp_dat", bus.rsp_dat, 0);
    tick();

    // Reset two cycles into the bus phase
    set_cmd(1'b0, 32'h0000_1000, 32'h0, 4'hF);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_cyc", bus.wbm_cyc_o, 0);
    check("mid_rst_stb", bus.wbm_stb_o, 0);
    check("mid_rst_rsp_valid", bus.rsp_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cmd_ready", bus.cmd_ready, 1);

`ifdef WB_TIMEOUT_EN
    // No ack: cycle abandoned after TO_CYCLES bus cycles
    set_cmd(1'b0, 32'h0000_2000, 32'h0, 4'hF);
    tick();
    bus.cmd_valid = 1'b0;
    n_cyc = 0;
    for (int i = 0; i < 40 && bus.wbm_cyc_o; i++) begin
      n_cyc++;
      tick();
    end
    check("to_bus_cycles", n_cyc, 8);
    check("to_rsp_valid", bus.rsp_valid, 1);
    check("to_rsp_err", bus.rsp_err, 1);
    check("to_rsp_dat", bus.rsp_dat, 0);
    tick();

    // Ack on the expiry cycle wins
    set_cmd(1'b0, 32'h0000_2004, 32'h0, 4'hF);
    tick();
    bus.cmd_valid = 1'b0;
    repeat (7) tick();
    bus.wbm_ack_i = 1'b1; bus.wbm_dat_i = 32'h0000_0077;
    tick();
    bus.wbm_ack_i = 1'b0;
    check("to_ack_rsp_err", bus.rsp_err, 0);
    check("to_ack_rsp_dat", bus.rsp_dat, 32'h0000_0077);
    check("to_ack_cyc_low", bus.wbm_cyc_o, 0);
    tick();
`else
    n_cyc = 0;
`endif

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      bus.cmd_valid = ($urandom_range(0, 9) < 6);
      bus.cmd_we    = 1'($urandom_range(0, 1));
      bus.cmd_adr   = $urandom;
      bus.cmd_dat   = $urandom;
      bus.cmd_sel   = 4'($urandom_range(0, 15));
      bus.rsp_ready = ($urandom_range(0, 1) == 1);
      bus.wbm_ack_i = ($urandom_range(0, 9) < 3);
      bus.wbm_dat_i = $urandom;
      tick();
    end

    // Drain
    bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b1; bus.wbm_ack_i = 1'b1;
    repeat (4) tick();
    check("drain_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
